// File: rtl/blk_pkg.sv
// Shared definitions for the block-column arbiter.
// Contents:
//   BLK_COLS  default columns per 4x4 block.
//   PIX_W     pixel width in bits.
//   COL_W     column width (four pixels).
//   state_e   arbiter state (IDLE: no grant, BUSY: one producer owns the path).
//   rr_winner round-robin winner id from a two-bit request vector and pointer.
package blk_pkg;

  localparam int unsigned BLK_COLS = 4;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned COL_W    = 4 * PIX_W;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  // The producer named by the pointer wins whenever it is requesting.
  // The result is only meaningful when at least one request bit is set.
  function automatic logic rr_winner(input logic [1:0] req, input logic rr);
    logic w_win;
    w_win = req[rr] ? rr : ~rr;
    return w_win;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin winner selection.
// Ports:
//   i_req  per-producer request bits.
//   i_rr   round-robin pointer; the producer it names has priority.
//   o_any  at least one request is present.
//   o_win  id of the winning producer (valid when o_any is high).
module rr_pick2
  import blk_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_rr,
  output logic       o_any,
  output logic       o_win
);

  assign o_any = |i_req;
  assign o_win = rr_winner(i_req, i_rr);

endmodule

// File: rtl/blk_col_arb.sv
// Block-level arbiter sharing one column output path between two producers.
// A granted producer owns the path until BLK_COLS valid columns have passed;
// blocks are never interleaved.
// Ports:
//   clk          rising-edge clock.
//   rst          synchronous active-high reset.
//   req_i        per-producer block request.
//   col0_i       producer 0 column data;  col0_ivalid its valid.
//   col1_i       producer 1 column data;  col1_ivalid its valid.
//   gnt_o        registered one-hot grant, 0 when idle.
//   col_o        registered column from the owner; holds when no column.
//   col_ovalid   col_o carries a fresh owner column.
//   col_osrc     producer id associated with col_o.
//   blk_done_o   high with the last column of a block on col_o.
//   err_o        sticky: a producer without the grant asserted its valid.
module blk_col_arb
  import blk_pkg::*;
#(
  parameter int unsigned BLK_COLS = blk_pkg::BLK_COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_i,
  input  logic [COL_W-1:0] col0_i,
  input  logic             col0_ivalid,
  input  logic [COL_W-1:0] col1_i,
  input  logic             col1_ivalid,
  output logic [1:0]       gnt_o,
  output logic [COL_W-1:0] col_o,
  output logic             col_ovalid,
  output logic             col_osrc,
  output logic             blk_done_o,
  output logic             err_o
);

  localparam int unsigned    CntW    = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BLK_COLS - 1);

  // State registers
  state_e           r_state;
  logic             r_gnt_id;
  logic             r_rr;
  logic [CntW-1:0]  r_cnt;
  logic [1:0]       r_gnt;
  logic [COL_W-1:0] r_col;
  logic             r_ovalid;
  logic             r_osrc;
  logic             r_done;
  logic             r_err;

  // Next-state and decode wires
  state_e           w_state_d;
  logic             w_gnt_id_d;
  logic             w_rr_d;
  logic [CntW-1:0]  w_cnt_d;
  logic [1:0]       w_gnt_d;
  logic             w_any;
  logic             w_win;
  logic             w_other;
  logic             w_busy;
  logic             w_own_valid;
  logic             w_oth_valid;
  logic             w_own_acc;
  logic             w_last;
  logic             w_bad;
  logic [COL_W-1:0] w_own_col;

  rr_pick2 u_pick (
    .i_req (req_i),
    .i_rr  (r_rr),
    .o_any (w_any),
    .o_win (w_win)
  );

  always_comb begin
    w_other     = ~r_gnt_id;
    w_busy      = (r_state == BUSY);
    w_own_valid = r_gnt_id ? col1_ivalid : col0_ivalid;
    w_oth_valid = r_gnt_id ? col0_ivalid : col1_ivalid;
    w_own_col   = r_gnt_id ? col1_i : col0_i;
    w_own_acc   = w_busy & w_own_valid;
    w_last      = w_own_acc & (r_cnt == CntLast);
    // While idle nobody holds the grant, so any valid is out of turn.
    w_bad       = w_busy ? w_oth_valid : (col0_ivalid | col1_ivalid);
  end

  always_comb begin
    w_state_d  = r_state;
    w_gnt_id_d = r_gnt_id;
    w_rr_d     = r_rr;
    w_cnt_d    = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_d  = BUSY;
          w_gnt_id_d = w_win;
        end
      end
      BUSY: begin
        if (w_last) begin
          w_cnt_d = '0;
          w_rr_d  = w_other;
          // The finishing owner never keeps the path; only the other side
          // can take it over without passing through IDLE.
          if (req_i[w_other]) begin
            w_gnt_id_d = w_other;
          end else begin
            w_state_d = IDLE;
          end
        end else if (w_own_acc) begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
    w_gnt_d = 2'b00;
    if (w_state_d == BUSY) begin
      w_gnt_d = w_gnt_id_d ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt_id <= 1'b0;
      r_rr     <= 1'b0;
      r_cnt    <= '0;
      r_gnt    <= 2'b00;
      r_col    <= '0;
      r_ovalid <= 1'b0;
      r_osrc   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_gnt_id <= w_gnt_id_d;
      r_rr     <= w_rr_d;
      r_cnt    <= w_cnt_d;
      r_gnt    <= w_gnt_d;
      if (w_own_acc) begin
        r_col <= w_own_col;
      end
      r_ovalid <= w_own_acc;
      r_osrc   <= r_gnt_id;
      r_done   <= w_last;
      if (w_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign gnt_o      = r_gnt;
  assign col_o      = r_col;
  assign col_ovalid = r_ovalid;
  assign col_osrc   = r_osrc;
  assign blk_done_o = r_done;
  assign err_o      = r_err;

endmodule

// File: tb/tb_blk_col_arb.sv
// Self-checking bench for blk_col_arb: a per-cycle vector table covering
// single, back-to-back, bubble/error, mid-block reset and dropped-request
// scenarios, followed by a hand-written fairness sequence.
module tb_blk_col_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req_i;
  logic [31:0] col0_i;
  logic        col0_ivalid;
  logic [31:0] col1_i;
  logic        col1_ivalid;
  logic [1:0]  gnt_o;
  logic [31:0] col_o;
  logic        col_ovalid;
  logic        col_osrc;
  logic        blk_done_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  blk_col_arb dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .col0_i      (col0_i),
    .col0_ivalid (col0_ivalid),
    .col1_i      (col1_i),
    .col1_ivalid (col1_ivalid),
    .gnt_o       (gnt_o),
    .col_o       (col_o),
    .col_ovalid  (col_ovalid),
    .col_osrc    (col_osrc),
    .blk_done_o  (blk_done_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        v0;
    logic [31:0] c0;
    logic        v1;
    logic [31:0] c1;
    logic [1:0]  e_gnt;
    logic [31:0] e_col;
    logic        e_ov;
    logic        e_src;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [1:0] rq, input logic v0, input logic [31:0] c0,
                     input logic v1, input logic [31:0] c1, input logic [1:0] eg,
                     input logic [31:0] ec, input logic eov, input logic esrc,
                     input logic edone, input logic eerr);
    vec_t v;
    v.rst = r;  v.req = rq; v.v0 = v0; v.c0 = c0; v.v1 = v1; v.c1 = c1;
    v.e_gnt = eg; v.e_col = ec; v.e_ov = eov; v.e_src = esrc; v.e_done = edone;
    v.e_err = eerr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] rq, input logic v0,
                       input logic [31:0] c0, input logic v1, input logic [31:0] c1);
    rst = r; req_i = rq; col0_ivalid = v0; col0_i = c0; col1_ivalid = v1; col1_i = c1;
  endtask

  initial begin
    drive(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    // rst, req, v0, c0, v1, c1 | gnt, col, ov, src, done, err
    // Single request from producer 0
    add(1, 2'b00, 0, 32'h0,        0, 32'h0, 2'b00, 32'h0,        0, 0, 0, 0);
    add(0, 2'b01, 0, 32'h0,        0, 32'h0, 2'b01, 32'h0,        0, 0, 0, 0);
    add(0, 2'b00, 1, 32'h11111111, 0, 32'h0, 2'b01, 32'h11111111, 1, 0, 0, 0);
    add(0, 2'b00, 1, 32'h22222222, 0, 32'h0, 2'b01, 32'h22222222, 1, 0, 0, 0);
    add(0, 2'b00, 1, 32'h33333333, 0, 32'h0, 2'b01, 32'h33333333, 1, 0, 0, 0);
    add(0, 2'b00, 1, 32'h44444444, 0, 32'h0, 2'b00, 32'h44444444, 1, 0, 1, 0);
    add(0, 2'b00, 0, 32'h0,        0, 32'h0, 2'b00, 32'h44444444, 0, 0, 0, 0);
    // Simultaneous requests after reset, direct handoff 0 -> 1
    add(1, 2'b00, 0, 32'h0,        0, 32'h0, 2'b00, 32'h0,        0, 0, 0, 0);
    add(0, 2'b11, 0, 32'h0,        0, 32'h0, 2'b01, 32'h0,        0, 0, 0, 0);
    add(0, 2'b11, 1, 32'hA0000001, 0, 32'h0, 2'b01, 32'hA0000001, 1, 0, 0, 0);
    add(0, 2'b11, 1, 32'hA0000002, 0, 32'h0, 2'b01, 32'hA0000002, 1, 0, 0, 0);
    add(0, 2'b11, 1, 32'hA0000003, 0, 32'h0, 2'b01, 32'hA0000003, 1, 0, 0, 0);
    add(0, 2'b10, 1, 32'hA0000004, 0, 32'h0, 2'b10, 32'hA0000004, 1, 0, 1, 0);
    add(0, 2'b00, 0, 32'h0, 1, 32'hB0000001, 2'b10, 32'hB0000001, 1, 1, 0, 0);
    add(0, 2'b00, 0, 32'h0, 1, 32'hB0000002, 2'b10, 32'hB0000002, 1, 1, 0, 0);
    add(0, 2'b00, 0, 32'h0, 1, 32'hB0000003, 2'b10, 32'hB0000003, 1, 1, 0, 0);
    add(0, 2'b00, 0, 32'h0, 1, 32'hB0000004, 2'b00, 32'hB0000004, 1, 1, 1, 0);
    add(0, 2'b00, 0, 32'h0,        0, 32'h0, 2'b00, 32'hB0000004, 0, 1, 0, 0);
    // Bubbles on the owner and a stray non-owner valid
    add(0, 2'b01, 0, 32'h0,        0, 32'h0, 2'b01, 32'hB0000004, 0, 1, 0, 0);
    add(0, 2'b00, 1, 32'hC0000001, 0, 32'h0, 2'b01, 32'hC0000001, 1, 0, 0, 0);
    add(0, 2'b00, 1, 32'hC0000002, 0, 32'h0, 2'b01, 32'hC0000002, 1, 0, 0, 0);
    add(0, 2'b00, 0, 32'h0, 1, 32'hDEADBEEF, 2'b01, 32'hC0000002, 0, 0, 0, 1);
    add(0, 2'b00, 0, 32'h0,        0, 32'h0, 2'b01, 32'hC0000002, 0, 0, 0, 1);
    add(0, 2'b00, 1, 32'hC0000003, 0, 32'h0, 2'b01, 32'hC0000003, 1, 0, 0, 1);
    add(0, 2'b00, 1, 32'hC0000004, 0, 32'h0, 2'b00, 32'hC0000004, 1, 0, 1, 1);
    add(0, 2'b00, 0, 32'h0,        0, 32'h0, 2'b00, 32'hC0000004, 0, 0, 0, 1);
    // Mid-block reset, then a fresh full block from producer 1
    add(1, 2'b00, 0, 32'h0,        0, 32'h0, 2'b00, 32'h0,        0, 0, 0, 0);
    add(0, 2'b01, 0, 32'h0,        0, 32'h0, 2'b01, 32'h0,        0, 0, 0, 0);
    add(0, 2'b00, 1, 32'hD0000001, 0, 32'h0, 2'b01, 32'hD0000001, 1, 0, 0, 0);
    add(0, 2'b00, 1, 32'hD0000002, 0, 32'h0, 2'b01, 32'hD0000002, 1, 0, 0, 0);
    add(1, 2'b00, 1, 32'hD0000003, 0, 32'h0, 2'b00, 32'h0,        0, 0, 0, 0);
    add(0, 2'b10, 0, 32'h0,        0, 32'h0, 2'b10, 32'h0,        0, 0, 0, 0);
    add(0, 2'b00, 0, 32'h0, 1, 32'hE0000001, 2'b10, 32'hE0000001, 1, 1, 0, 0);
    add(0, 2'b00, 0, 32'h0, 1, 32'hE0000002, 2'b10, 32'hE0000002, 1, 1, 0, 0);
    add(0, 2'b00, 0, 32'h0, 1, 32'hE0000003, 2'b10, 32'hE0000003, 1, 1, 0, 0);
    add(0, 2'b00, 0, 32'h0, 1, 32'hE0000004, 2'b00, 32'hE0000004, 1, 1, 1, 0);
    // Owner drops its request after the first column
    add(0, 2'b01, 0, 32'h0,        0, 32'h0, 2'b01, 32'hE0000004, 0, 1, 0, 0);
    add(0, 2'b01, 1, 32'hF0000001, 0, 32'h0, 2'b01, 32'hF0000001, 1, 0, 0, 0);
    add(0, 2'b00, 1, 32'hF0000002, 0, 32'h0, 2'b01, 32'hF0000002, 1, 0, 0, 0);
    add(0, 2'b00, 1, 32'hF0000003, 0, 32'h0, 2'b01, 32'hF0000003, 1, 0, 0, 0);
    add(0, 2'b00, 1, 32'hF0000004, 0, 32'h0, 2'b00, 32'hF0000004, 1, 0, 1, 0);
    add(0, 2'b00, 0, 32'h0,        0, 32'h0, 2'b00, 32'hF0000004, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].v0, tbl[i].c0, tbl[i].v1, tbl[i].c1);
      step();
      chk("gnt_o",      i, 32'(gnt_o),      32'(tbl[i].e_gnt));
      chk("col_o",      i, col_o,           tbl[i].e_col);
      chk("col_ovalid", i, 32'(col_ovalid), 32'(tbl[i].e_ov));
      chk("col_osrc",   i, 32'(col_osrc),   32'(tbl[i].e_src));
      chk("blk_done_o", i, 32'(blk_done_o), 32'(tbl[i].e_done));
      chk("err_o",      i, 32'(err_o),      32'(tbl[i].e_err));
    end

    // Fairness: both producers request continuously for four blocks.
    drive(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    drive(1'b0, 2'b11, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    for (int b = 0; b < 4; b++) begin
      logic        exp_id;
      logic [1:0]  exp_gnt;
      logic [31:0] data;
      exp_id  = b[0];
      exp_gnt = exp_id ? 2'b10 : 2'b01;
      for (int k = 0; k < 4; k++) begin
        chk("fair_gnt", b * 4 + k, 32'(gnt_o), 32'(exp_gnt));
        data = 32'h50000000 | (b << 8) | k;
        drive(1'b0, 2'b11, ~exp_id, data, exp_id, data);
        step();
        chk("fair_col",  b * 4 + k, col_o,           data);
        chk("fair_ov",   b * 4 + k, 32'(col_ovalid), 32'd1);
        chk("fair_src",  b * 4 + k, 32'(col_osrc),   32'(exp_id));
        chk("fair_done", b * 4 + k, 32'(blk_done_o), (k == 3) ? 32'd1 : 32'd0);
      end
    end
    chk("fair_next_gnt", 16, 32'(gnt_o), 32'(2'b01));
    chk("fair_err",      16, 32'(err_o), 32'd0);

    drive(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    chk("final_rst_gnt", 17, 32'(gnt_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blk_col_arb.md
# blk_col_arb

Block-level arbiter sharing one 32-bit block-column output path between two column producers. Each 4x4 block travels as BLK_COLS consecutive 32-bit columns of four 8-bit pixels, and blocks are never interleaved. A granted producer owns the path until exactly BLK_COLS valid columns have been transferred. The arbiter sits between the two prediction/transform column sources and the block-column delay line that feeds the output stage.

## Interface
- BLK_COLS, 4, columns per block; legal range 2..16.
- COL_W, 32, column width in bits (4 pixels x 8 bits).
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_i  in  2  per-producer request for one block; bit k = producer k.
- col0_i  in  COL_W  producer 0 column data.
- col0_ivalid  in  1  producer 0 column valid.
- col1_i  in  COL_W  producer 1 column data.
- col1_ivalid  in  1  producer 1 column valid.
- gnt_o  out  2  one-hot grant (or 0); registered.
- col_o  out  COL_W  granted column, registered.
- col_ovalid  out  1  col_o valid.
- col_osrc  out  1  producer id of col_o.
- blk_done_o  out  1  pulse aligned with the last column of a block on col_o.
- err_o  out  1  sticky; set when a non-granted producer asserts its valid.

## Operation
- States:
  - IDLE: gnt_o=0.
  - BUSY: gnt_o one-hot, owner id in gnt_id.
- Round-robin pointer rr is 1 bit and resets to 0. A request from producer rr wins over a request from producer ~rr.
- IDLE -> BUSY when req_i != 0. The winner is picked by rr, and gnt_o takes the winner's bit on the next edge.
- In BUSY, the column counter cnt (width clog2(BLK_COLS), reset 0) increments on each cycle where the owner's valid is high.
- Non-owner valid is dropped and sets err_o. err_o clears only on rst.
- Last column is the owner's valid while cnt==BLK_COLS-1. On that edge:
  - cnt <= 0.
  - rr <= ~gnt_id.
  - If req_i[~gnt_id]=1: grant hands over directly to ~gnt_id and the state stays BUSY.
  - Else: the state goes to IDLE. The current owner is never re-granted directly; it re-competes from IDLE.
- Blocks are atomic. Dropping the owner's req_i mid-block is ignored, and the grant is held until BLK_COLS columns have been transferred.
- Owner valid may have bubbles; cnt holds during bubbles.
- Both producers requesting from IDLE: rr wins.
- Datapath:
  - col_o <= owner column when owner valid, else col_o holds.
  - col_ovalid <= owner valid & BUSY.
  - col_osrc <= gnt_id.
- blk_done_o <= last-column condition.
- rst mid-block: all state clears on the next edge, the partial block is abandoned, and no blk_done_o is produced.
- Reset values: gnt_o=0, col_o=0, col_ovalid=0, col_osrc=0, blk_done_o=0, err_o=0, rr=0, cnt=0, state IDLE.

## Timing
- Request to grant: req_i sampled at edge N in IDLE gives gnt_o at N+1. The producer may drive its first valid in the first cycle gnt_o is high.
- Data latency: owner column valid in cycle N appears on col_o/col_ovalid in cycle N+1.
- Back-to-back with handoff: the last column of A is in cycle N, and gnt_o switches to B in N+1. B's first column can be accepted in N+1, so there are no idle cycles.
- Handoff to nobody: gnt_o=0 in N+1, and the earliest new grant is N+2.
- Throughput is one column per cycle while the owner streams. A block with no bubbles occupies exactly BLK_COLS grant cycles.

## Structure
- Shared package blk_pkg holds:
  - BLK_COLS, PIX_W=8, COL_W=4*PIX_W.
  - The state enum {IDLE, BUSY}.
  - A function that returns the winner id from (req, rr).
- One natural sub-module is rr_pick2: combinational two-way round-robin winner selection, instantiated once. All other logic stays in blk_col_arb.

## Test plan
- Single request: req_i=01, then four columns 0x11111111..0x44444444 back-to-back. Expected: gnt_o=01 one cycle after req, col_o reproduces the four columns each one cycle late with col_osrc=0, blk_done_o on 0x44444444, then IDLE with gnt_o=00.
- Simultaneous requests after reset: req_i=11 with each producer streaming 4 columns. Expected: producer 0 is granted first, handoff to producer 1 happens with no gap, and eight consecutive col_ovalid cycles appear with col_osrc 0,0,0,0,1,1,1,1.
- Fairness: both producers hold req_i=11 for 4 blocks. Expected: grant order 0,1,0,1 and no producer wins twice in a row.
- Bubbles and drops: the owner streams with a 2-cycle gap after column 2, and the non-owner pulses valid once. Expected: blk_done_o only after the 4th owner column, the non-owner data never appears on col_o, and err_o=1 and stays 1.
- Mid-block reset: rst pulsed after 2 of 4 columns. Expected: next cycle all outputs are 0, no blk_done_o, and a fresh req_i=10 then gets gnt_o=10 within 1 cycle.
- Owner drops req mid-block: req_i[0] falls after column 1. Expected: gnt_o stays 01 until column 4, then blk_done_o and IDLE.
